// File: rtl/cmd_rdexec_ctrl.sv
// Command read/execute controller: accepts an 8-bit command, reads two operands
// from an external 4-entry register file, runs an 8-bit ALU op and strobes the
// result back through an active-low writeback enable.
module cmd_rdexec_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] R0,
  input  logic [7:0] R1,
  input  logic [7:0] R2,
  input  logic [7:0] R3,
  output logic [7:0] res_alu,
  output logic [1:0] res_dest,
  output logic       enact,
  output logic       busy,
  output logic       done,
  output logic       zf,
  output logic       cf
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  localparam logic [2:0] OpMov = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpNot = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] op_q;
  logic [1:0] rs_q, rd_q;
  logic [7:0] a_q, b_q;
  logic [7:0] res_alu_q;
  logic [1:0] res_dest_q;
  logic       zf_q, cf_q;

  logic       accept;
  logic [7:0] rd_val, rs_val;
  logic [8:0] alu_wide;

  assign accept = cmd_valid && (state_q == StIdle);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and decoded outputs; outputs derive from the state register so
  // that reset deasserts the writeback strobe without a clock.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    enact     = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StRead;
      end
      StRead: state_d = StExec;
      StExec: state_d = StWb;
      StWb: begin
        done    = 1'b1;
        enact   = (op_q == OpCmp);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = ~cmd_ready;

  // Command field latch on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 3'b000;
      rs_q <= 2'b00;
      rd_q <= 2'b00;
    end else if (accept) begin
      op_q <= cmd[7:5];
      rs_q <= cmd[3:2];
      rd_q <= cmd[1:0];
    end
  end

  // Register-file read ports for destination (operand A) and source (operand B).
  always_comb begin
    rd_val = R0;
    rs_val = R0;
    unique case (rd_q)
      2'd0: rd_val = R0;
      2'd1: rd_val = R1;
      2'd2: rd_val = R2;
      2'd3: rd_val = R3;
      default: rd_val = R0;
    endcase
    unique case (rs_q)
      2'd0: rs_val = R0;
      2'd1: rs_val = R1;
      2'd2: rs_val = R2;
      2'd3: rs_val = R3;
      default: rs_val = R0;
    endcase
  end

  // Operand latch: the register file is sampled only on the READ->EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else if (state_q == StRead) begin
      a_q <= rd_val;
      b_q <= rs_val;
    end
  end

  // ALU; bit 8 carries the carry (ADD) or borrow (SUB/CMP), zero otherwise.
  always_comb begin
    alu_wide = 9'h000;
    unique case (op_q)
      OpMov: alu_wide = {1'b0, b_q};
      OpAdd: alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OpSub: alu_wide = {1'b0, a_q} - {1'b0, b_q};
      OpAnd: alu_wide = {1'b0, a_q & b_q};
      OpOr:  alu_wide = {1'b0, a_q | b_q};
      OpXor: alu_wide = {1'b0, a_q ^ b_q};
      OpNot: alu_wide = {1'b0, ~b_q};
      OpCmp: alu_wide = {1'b0, a_q} - {1'b0, b_q};
      default: alu_wide = 9'h000;
    endcase
  end

  // Result and flag registers, updated only on the EXEC->WB edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_alu_q  <= 8'h00;
      res_dest_q <= 2'b00;
      zf_q       <= 1'b0;
      cf_q       <= 1'b0;
    end else if (state_q == StExec) begin
      res_alu_q  <= alu_wide[7:0];
      res_dest_q <= rd_q;
      zf_q       <= (alu_wide[7:0] == 8'h00);
      cf_q       <= alu_wide[8];
    end
  end

  assign res_alu  = res_alu_q;
  assign res_dest = res_dest_q;
  assign zf       = zf_q;
  assign cf       = cf_q;

endmodule

// File: tb/tb_cmd_rdexec_ctrl.sv
// Self-checking bench for cmd_rdexec_ctrl: directed scenarios plus randomized
// commands checked against an arithmetic reference model and a register file.
module tb_cmd_rdexec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       cmd_ready;
  logic [7:0] R0, R1, R2, R3;
  logic [7:0] res_alu;
  logic [1:0] res_dest;
  logic       enact, busy, done, zf, cf;

  int n_vec = 0;
  int n_err = 0;

  // Register file seen by the DUT, and the model's expectation of it.
  logic [7:0] rf [4];
  logic [7:0] new_rf [4];
  logic       rf_load;
  int         exp_rf [4];

  // Model of the last registered result and flags.
  int m_res, m_dest, m_zf, m_cf;

  always #5 clk = ~clk;

  cmd_rdexec_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .R0        (R0),
    .R1        (R1),
    .R2        (R2),
    .R3        (R3),
    .res_alu   (res_alu),
    .res_dest  (res_dest),
    .enact     (enact),
    .busy      (busy),
    .done      (done),
    .zf        (zf),
    .cf        (cf)
  );

  assign R0 = rf[0];
  assign R1 = rf[1];
  assign R2 = rf[2];
  assign R3 = rf[3];

  // Register file: bench loads, or falling-edge writeback while enact is low.
  always @(negedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 4; i++) rf[i] <= new_rf[i];
    end else if (!enact) begin
      rf[res_dest] <= res_alu;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  task automatic model(input int op, input int a, input int b, output int r, output int c);
    c = 0;
    case (op)
      0: r = b;
      1: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      2, 7: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: r = 255 - b;
    endcase
  endtask

  // Called at posedge+1 while idle; consumes one cycle.
  task automatic load_rf(input int v0, input int v1, input int v2, input int v3);
    new_rf[0] = v0[7:0]; new_rf[1] = v1[7:0]; new_rf[2] = v2[7:0]; new_rf[3] = v3[7:0];
    exp_rf[0] = v0 % 256; exp_rf[1] = v1 % 256; exp_rf[2] = v2 % 256; exp_rf[3] = v3 % 256;
    rf_load = 1'b1;
    @(negedge clk); #1;
    rf_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_res"}, res_alu, m_res);
    check({tag, "_dest"}, res_dest, m_dest);
    check({tag, "_zf"}, zf, m_zf);
    check({tag, "_cf"}, cf, m_cf);
  endtask

  // Issue one command from IDLE (at posedge+1) and follow it through WB.
  task automatic issue(input int op, input int rs, input int rd, input bit stall);
    int a, b, r, c;
    check("ready_idle", cmd_ready, 1);
    a = exp_rf[rd];
    b = exp_rf[rs];
    model(op, a, b, r, c);
    cmd_valid = 1'b1;
    cmd = {op[2:0], 1'($urandom_range(0, 1)), rs[1:0], rd[1:0]};
    @(posedge clk); #1;
    cmd_valid = stall;
    cmd = 8'($urandom);
    check("read_busy", busy, 1);
    check("read_ready", cmd_ready, 0);
    check("read_done", done, 0);
    check("read_enact", enact, 1);
    check_held("read");
    @(posedge clk); #1;
    cmd = 8'($urandom);
    check("exec_busy", busy, 1);
    check("exec_done", done, 0);
    check("exec_enact", enact, 1);
    check_held("exec");
    @(posedge clk); #1;
    m_res = r; m_dest = rd; m_zf = (r == 0) ? 1 : 0; m_cf = c;
    check("wb_busy", busy, 1);
    check("wb_done", done, 1);
    check("wb_enact", enact, (op == 7) ? 1 : 0);
    check_held("wb");
    if (op != 7) exp_rf[rd] = r;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_enact", enact, 1);
    check_held("idle");
    for (int i = 0; i < 4; i++) check("rf", rf[i], exp_rf[i]);
  endtask

  initial begin
    int old_rd;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 8'h00;
    rf_load = 1'b0;
    for (int i = 0; i < 4; i++) begin rf[i] = 8'h00; new_rf[i] = 8'h00; exp_rf[i] = 0; end
    m_res = 0; m_dest = 0; m_zf = 0; m_cf = 0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enact", enact, 1);
    check_held("rst");
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with carry out.
    load_rf(8'h11, 8'hF0, 8'h20, 8'h33);
    issue(1, 2, 1, 1'b0);
    check("add_res", res_alu, 8'h10);
    check("add_cf", cf, 1);
    // SUB with borrow.
    load_rf(8'h05, 8'h44, 8'h55, 8'h07);
    issue(2, 3, 0, 1'b0);
    check("sub_res", res_alu, 8'hFE);
    check("sub_cf", cf, 1);
    // CMP of equal values: flags only, no write.
    load_rf(8'h01, 8'h3C, 8'h3C, 8'h02);
    issue(7, 1, 2, 1'b0);
    check("cmp_zf", zf, 1);
    check("cmp_rf2", rf[2], 8'h3C);
    // Back-to-back dependency: MOV R0<-R1, then XOR R0^R0.
    load_rf(8'h00, 8'hAA, 8'h00, 8'h00);
    issue(0, 1, 0, 1'b0);
    check("mov_res", res_alu, 8'hAA);
    issue(5, 0, 0, 1'b0);
    check("xor_res", res_alu, 8'h00);
    check("xor_zf", zf, 1);
    // rs == rd SUB yields zero; command changes while busy are ignored.
    load_rf(8'h9C, 8'h12, 8'h34, 8'h56);
    issue(2, 3, 3, 1'b1);
    check("subsame_zf", zf, 1);
    issue(6, 1, 2, 1'b1);

    // Reset during WB of an ADD aborts the writeback.
    load_rf(8'h10, 8'h20, 8'h30, 8'h40);
    old_rd = exp_rf[3];
    cmd_valid = 1'b1;
    cmd = 8'b001_0_01_11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_wb_enact", enact, 0);
    #2 rst_n = 1'b0;
    #1;
    m_res = 0; m_dest = 0; m_zf = 0; m_cf = 0;
    check("abort_enact", enact, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check_held("abort");
    @(negedge clk); #1;
    check("abort_nowrite", rf[3], old_rd);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_after_ready", cmd_ready, 1);
    check_held("abort_after");

    // Randomized commands with occasional register reloads and idle gaps.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        load_rf(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        cmd = 8'($urandom);
        @(posedge clk); #1;
        check("gap_ready", cmd_ready, 1);
        check_held("gap");
      end
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
